// File: rtl/gf180mcu_fd_sc_mcu7t5v0__dbsync3.sv
// Three-channel synchronizer + debounce filter feeding a downstream OR3.
// Define GF180MCU_FD_SC_MCU7T5V0__DBSYNC3_STICKY_EN to make each output a sticky flag with clear.
module gf180mcu_fd_sc_mcu7t5v0__dbsync3 #(
  parameter int SYNC_STAGES = 2,
  parameter int DB_CNT_W    = 4,
  parameter int DB_LEN      = 8
) (
  input  logic CLK,
  input  logic RST,
  input  logic D1,
  input  logic D2,
  input  logic D3,
  input  logic EN,
  input  logic CLR1,
  input  logic CLR2,
  input  logic CLR3,
  output logic Q1,
  output logic Q2,
  output logic Q3,
  output logic BUSY
);

  typedef enum logic {STABLE = 1'b0, COUNT = 1'b1} db_state_t;

  localparam logic [DB_CNT_W-1:0] CNT_TC  = DB_CNT_W'(DB_LEN - 1);
  localparam logic [DB_CNT_W-1:0] CNT_ONE = DB_CNT_W'(1);

  logic [2:0] d;
  logic [2:0] clr;
  logic [2:0] q;
  logic [2:0] busy_ch;

  assign d   = {D3, D2, D1};
  assign clr = {CLR3, CLR2, CLR1};

  for (genvar ch = 0; ch < 3; ch++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync;
    logic                   s;
    logic                   f;
    logic [DB_CNT_W-1:0]    cnt;
    db_state_t              state;

    // Synchronizer keeps sampling even while the filter is frozen.
    always_ff @(posedge CLK or posedge RST) begin
      if (RST) sync <= '0;
      else     sync <= {sync[SYNC_STAGES-2:0], d[ch]};
    end

    assign s = sync[SYNC_STAGES-1];

    always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
        state <= STABLE;
        cnt   <= '0;
        f     <= 1'b0;
      end else if (EN) begin
        case (state)
          STABLE: begin
            if (s != f) begin
              if (DB_LEN == 1) begin
                f <= s;
              end else begin
                cnt   <= CNT_ONE;
                state <= COUNT;
              end
            end
          end
          COUNT: begin
            if (s == f) begin
              cnt   <= '0;
              state <= STABLE;
            end else if (cnt == CNT_TC) begin
              f     <= s;
              cnt   <= '0;
              state <= STABLE;
            end else begin
              cnt <= cnt + CNT_ONE;
            end
          end
          default: begin
            cnt   <= '0;
            state <= STABLE;
          end
        endcase
      end
    end

    assign busy_ch[ch] = (cnt != '0);

`ifdef GF180MCU_FD_SC_MCU7T5V0__DBSYNC3_STICKY_EN
    logic sticky;
    logic rise;

    // Rising acceptance: same condition that moves f from 0 to 1 this edge.
    assign rise = EN && s && !f &&
                  (((state == COUNT) && (cnt == CNT_TC)) ||
                   ((DB_LEN == 1) && (state == STABLE)));

    always_ff @(posedge CLK or posedge RST) begin
      if (RST)          sticky <= 1'b0;
      else if (rise)    sticky <= 1'b1;
      else if (clr[ch]) sticky <= 1'b0;
    end

    assign q[ch] = sticky;
`else
    assign q[ch] = f;
`endif
  end

`ifndef GF180MCU_FD_SC_MCU7T5V0__DBSYNC3_STICKY_EN
  logic unused_clr;
  assign unused_clr = ^clr;
`endif

  assign Q1   = q[0];
  assign Q2   = q[1];
  assign Q3   = q[2];
  assign BUSY = |busy_ch;

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu7t5v0__dbsync3.sv
// Bench for the three-channel synchronizer/debounce block: directed scenarios
// followed by random traffic, all checked against a run-length reference model.
module tb_gf180mcu_fd_sc_mcu7t5v0__dbsync3;

  localparam int SYNC_STAGES = 2;
  localparam int DB_LEN      = 8;

  logic CLK = 1'b0;
  logic RST, D1, D2, D3, EN, CLR1, CLR2, CLR3;
  logic Q1, Q2, Q3, BUSY;

  int vectors     = 0;
  int miscompares = 0;

  bit sh   [3][SYNC_STAGES];
  bit f_m  [3];
  int run_m[3];
  bit st_m [3];

`ifdef GF180MCU_FD_SC_MCU7T5V0__DBSYNC3_STICKY_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif

  always #5 CLK = ~CLK;

  gf180mcu_fd_sc_mcu7t5v0__dbsync3 #(
    .SYNC_STAGES(SYNC_STAGES),
    .DB_CNT_W   (4),
    .DB_LEN     (DB_LEN)
  ) dut (
    .CLK (CLK),
    .RST (RST),
    .D1  (D1),
    .D2  (D2),
    .D3  (D3),
    .EN  (EN),
    .CLR1(CLR1),
    .CLR2(CLR2),
    .CLR3(CLR3),
    .Q1  (Q1),
    .Q2  (Q2),
    .Q3  (Q3),
    .BUSY(BUSY)
  );

  function automatic void model_reset();
    for (int ch = 0; ch < 3; ch++) begin
      for (int k = 0; k < SYNC_STAGES; k++) sh[ch][k] = 1'b0;
      f_m[ch]   = 1'b0;
      run_m[ch] = 0;
      st_m[ch]  = 1'b0;
    end
  endfunction

  // Filter rule: a differing level must be seen for DB_LEN consecutive
  // enabled cycles; any enabled cycle where it matches restarts the run.
  function automatic void model_edge(input logic [2:0] dv, input logic en_v,
                                     input logic [2:0] clr_v);
    bit s_pre;
    bit old_f;
    for (int ch = 0; ch < 3; ch++) begin
      s_pre = sh[ch][SYNC_STAGES-1];
      for (int k = SYNC_STAGES - 1; k > 0; k--) sh[ch][k] = sh[ch][k-1];
      sh[ch][0] = dv[ch];
      old_f = f_m[ch];
      if (en_v) begin
        if (s_pre != f_m[ch]) begin
          run_m[ch] = run_m[ch] + 1;
          if (run_m[ch] >= DB_LEN) begin
            f_m[ch]   = s_pre;
            run_m[ch] = 0;
          end
        end else begin
          run_m[ch] = 0;
        end
      end
      if (!old_f && f_m[ch]) st_m[ch] = 1'b1;
      else if (clr_v[ch])    st_m[ch] = 1'b0;
    end
  endfunction

  task automatic check();
    logic [2:0] qv;
    logic [2:0] qe;
    logic       be;
    qv = {Q3, Q2, Q1};
    be = 1'b0;
    for (int ch = 0; ch < 3; ch++) begin
      qe[ch] = STICKY ? st_m[ch] : f_m[ch];
      if (run_m[ch] != 0) be = 1'b1;
    end
    for (int ch = 0; ch < 3; ch++) begin
      vectors++;
      assert (qv[ch] === qe[ch]) else begin
        miscompares++;
        $error("FAIL q%0d: observed %b expected %b at %0t", ch + 1, qv[ch], qe[ch], $time);
      end
    end
    vectors++;
    assert (BUSY === be) else begin
      miscompares++;
      $error("FAIL busy: observed %b expected %b at %0t", BUSY, be, $time);
    end
  endtask

  task automatic step(input logic [2:0] dv, input logic en_v,
                      input logic [2:0] clr_v, input logic rst_v);
    @(negedge CLK);
    {D3, D2, D1}       = dv;
    EN                 = en_v;
    {CLR3, CLR2, CLR1} = clr_v;
    RST                = rst_v;
    if (rst_v) model_reset();
    @(posedge CLK);
    if (rst_v) model_reset();
    else       model_edge(dv, en_v, clr_v);
    #1;
    check();
  endtask

  initial begin
    int lat;
    int busy_n;
    int hi_n;
    logic [2:0] dv;
    logic [2:0] cv;
    logic       ev;
    logic       rv;

    {D3, D2, D1} = 3'b111;
    EN = 1'b1;
    {CLR3, CLR2, CLR1} = 3'b000;
    RST = 1'b1;
    model_reset();

    // Reset held with inputs high; then full latency after release.
    for (int i = 0; i < 5; i++) step(3'b111, 1'b1, 3'b000, 1'b1);
    lat = 0;
    for (int i = 1; i <= 30 && lat == 0; i++) begin
      step(3'b111, 1'b1, 3'b000, 1'b0);
      if (Q1 === 1'b1 && Q2 === 1'b1 && Q3 === 1'b1) lat = i;
    end
    vectors++;
    assert (lat == 10) else begin
      miscompares++;
      $error("FAIL reset_latency: observed %0d expected 10", lat);
    end

    for (int i = 0; i < 14; i++) step(3'b000, 1'b1, 3'b000, 1'b0);
    step(3'b000, 1'b1, 3'b111, 1'b0);

    // EN freeze for 4 cycles after 3 counted cycles.
    lat = 0;
    for (int i = 1; i <= 40 && lat == 0; i++) begin
      step(3'b001, (i >= 6 && i <= 9) ? 1'b0 : 1'b1, 3'b000, 1'b0);
      if (Q1 === 1'b1) lat = i;
    end
    vectors++;
    assert (lat == 14) else begin
      miscompares++;
      $error("FAIL en_freeze_latency: observed %0d expected 14", lat);
    end

    // Five-cycle glitch on D2.
    busy_n = 0;
    hi_n   = 0;
    for (int i = 1; i <= 17; i++) begin
      step((i <= 5) ? 3'b011 : 3'b001, 1'b1, 3'b000, 1'b0);
      if (BUSY === 1'b1) busy_n++;
      if (Q2 === 1'b1) hi_n++;
    end
    vectors++;
    assert (busy_n == 5) else begin
      miscompares++;
      $error("FAIL glitch_busy: observed %0d expected 5", busy_n);
    end
    vectors++;
    assert (hi_n == 0) else begin
      miscompares++;
      $error("FAIL glitch_q2: observed %0d expected 0", hi_n);
    end

    // Reset mid-count on D3.
    for (int i = 0; i < 6; i++) step(3'b101, 1'b1, 3'b000, 1'b0);
    step(3'b101, 1'b1, 3'b000, 1'b1);
    lat = 0;
    for (int i = 1; i <= 30 && lat == 0; i++) begin
      step(3'b101, 1'b1, 3'b000, 1'b0);
      if (Q3 === 1'b1) lat = i;
    end
    vectors++;
    assert (lat == 10) else begin
      miscompares++;
      $error("FAIL reset_midcount_latency: observed %0d expected 10", lat);
    end

`ifdef GF180MCU_FD_SC_MCU7T5V0__DBSYNC3_STICKY_EN
    for (int i = 0; i < 15; i++) step(3'b000, 1'b1, 3'b000, 1'b0);
    vectors++;
    assert (Q1 === 1'b1) else begin
      miscompares++;
      $error("FAIL sticky_hold: observed %b expected 1", Q1);
    end
    step(3'b000, 1'b1, 3'b001, 1'b0);
    vectors++;
    assert (Q1 === 1'b0) else begin
      miscompares++;
      $error("FAIL sticky_clear: observed %b expected 0", Q1);
    end
    for (int i = 1; i <= 10; i++) step(3'b001, 1'b1, (i == 10) ? 3'b001 : 3'b000, 1'b0);
    vectors++;
    assert (Q1 === 1'b1) else begin
      miscompares++;
      $error("FAIL sticky_set_wins: observed %b expected 1", Q1);
    end
    step(3'b001, 1'b1, 3'b001, 1'b0);
    vectors++;
    assert (Q1 === 1'b0) else begin
      miscompares++;
      $error("FAIL sticky_clear_alone: observed %b expected 0", Q1);
    end
`else
    for (int i = 0; i < 12; i++) step(3'b000, 1'b1, 3'b000, 1'b0);
    lat  = 0;
    hi_n = 0;
    for (int i = 1; i <= 40; i++) begin
      step((i <= 20) ? 3'b010 : 3'b000, 1'b1, (i % 2 == 1) ? 3'b010 : 3'b000, 1'b0);
      if (Q2 === 1'b1) begin
        hi_n++;
        if (lat == 0) lat = i;
      end
    end
    vectors++;
    assert (lat == 10) else begin
      miscompares++;
      $error("FAIL pulse_rise: observed %0d expected 10", lat);
    end
    vectors++;
    assert (hi_n == 20) else begin
      miscompares++;
      $error("FAIL pulse_width: observed %0d expected 20", hi_n);
    end
`endif

    // Random traffic: level flips of mixed duration, occasional freezes,
    // clears and resets.
    dv = 3'b000;
    for (int i = 0; i < 3000; i++) begin
      for (int ch = 0; ch < 3; ch++) begin
        if ($urandom_range(0, 5) == 0) dv[ch] = ~dv[ch];
        cv[ch] = ($urandom_range(0, 7) == 0);
      end
      ev = ($urandom_range(0, 7) != 0);
      rv = ($urandom_range(0, 499) == 0);
      step(dv, ev, cv, rv);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
